// File: rtl/alu_md_if.sv
// alu_md_if: issue/result bundle for the alu_md EX-stage unit.
//   in_valid/in_ready    : issue handshake (master -> slave / slave -> master)
//   alu_op, alu_srcA     : operation code and shift-amount source select
//   alu_a, alu_b         : operands
//   out_valid, alu_res   : single-cycle result strobe and result
//   alu_int_ov           : signed overflow of ADD/SUB
//   hi, lo               : architectural HI/LO registers
// The master modport is the issuing side; the slave modport is alu_md.
interface alu_md_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_op;
  logic             alu_srcA;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             out_valid;
  logic [WIDTH-1:0] alu_res;
  logic             alu_int_ov;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, alu_op, alu_srcA, alu_a, alu_b,
    input  in_ready, out_valid, alu_res, alu_int_ov, hi, lo
  );

  modport slave (
    input  in_valid, alu_op, alu_srcA, alu_a, alu_b,
    output in_ready, out_valid, alu_res, alu_int_ov, hi, lo
  );
endinterface

// File: rtl/alu_md.sv
// alu_md: registered EX-stage ALU with an iterative multiply/divide unit.
//   clk    : clock
//   reset  : asynchronous, active-low reset
//   flush  : kills an op accepted this cycle or in flight; hi/lo untouched
//   bus    : alu_md_if slave (issue handshake, operands, result, hi/lo)
// Single-cycle ops produce a one-cycle out_valid strobe after the accepting
// edge. MULT/MULTU/DIV/DIVU run WIDTH iterations on operand magnitudes,
// then a sign-fix cycle that writes {hi,lo} and strobes out_valid.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     reset,
  input logic     flush,
  alu_md_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_MULT  = 5'b00010;
  localparam logic [4:0] OP_MULTU = 5'b00011;
  localparam logic [4:0] OP_SRL   = 5'b00100;
  localparam logic [4:0] OP_DIV   = 5'b00110;
  localparam logic [4:0] OP_DIVU  = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b01000;
  localparam logic [4:0] OP_SUB   = 5'b01001;
  localparam logic [4:0] OP_SLT   = 5'b01010;
  localparam logic [4:0] OP_SLTU  = 5'b01011;
  localparam logic [4:0] OP_SRA   = 5'b01100;
  localparam logic [4:0] OP_MFHI  = 5'b01101;
  localparam logic [4:0] OP_MFLO  = 5'b01110;
  localparam logic [4:0] OP_MTHI  = 5'b01111;
  localparam logic [4:0] OP_NOR   = 5'b10000;
  localparam logic [4:0] OP_MTLO  = 5'b10001;
  localparam logic [4:0] OP_SLL   = 5'b10100;
  localparam logic [4:0] OP_XOR   = 5'b11000;
  localparam logic [4:0] OP_LUI   = 5'b11100;

  logic [1:0]         state;
  logic [SHW-1:0]     count;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand, divisor, quo, rem, dividend_raw;
  logic               is_div, neg_q, neg_r, div_zero;
  logic               out_valid_q, ov_q;
  logic [WIDTH-1:0]   res_q, hi_q, lo_q;

  logic               accept, is_multi, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, sum, diff_ab, res_c;
  logic               ov_c;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     upper_sum, shifted;
  logic [WIDTH-1:0]   div_diff, fix_hi, fix_lo;
  logic               fits;

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_res    = res_q;
  assign bus.alu_int_ov = ov_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

  assign accept    = bus.in_valid && (state == S_IDLE);
  assign is_multi  = (bus.alu_op == OP_MULT) || (bus.alu_op == OP_MULTU) ||
                     (bus.alu_op == OP_DIV)  || (bus.alu_op == OP_DIVU);
  assign signed_op = (bus.alu_op == OP_MULT) || (bus.alu_op == OP_DIV);
  assign a_neg     = signed_op && bus.alu_a[WIDTH-1];
  assign b_neg     = signed_op && bus.alu_b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.alu_a : bus.alu_a;
  assign b_mag     = b_neg ? -bus.alu_b : bus.alu_b;
  assign shamt     = bus.alu_srcA ? bus.alu_a[6 +: SHW] : bus.alu_a[SHW-1:0];
  assign sum       = bus.alu_a + bus.alu_b;
  assign diff_ab   = bus.alu_a - bus.alu_b;

  // Single-cycle result; MFHI/MFLO see hi/lo as they stand before the edge.
  always_comb begin
    res_c = '0;
    ov_c  = 1'b0;
    case (bus.alu_op)
      OP_AND:  res_c = bus.alu_a & bus.alu_b;
      OP_OR:   res_c = bus.alu_a | bus.alu_b;
      OP_NOR:  res_c = ~(bus.alu_a | bus.alu_b);
      OP_XOR:  res_c = bus.alu_a ^ bus.alu_b;
      OP_ADD: begin
        res_c = sum;
        ov_c  = (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.alu_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff_ab;
        ov_c  = (bus.alu_a[WIDTH-1] != bus.alu_b[WIDTH-1]) &&
                (diff_ab[WIDTH-1] != bus.alu_a[WIDTH-1]);
      end
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (bus.alu_a < bus.alu_b)};
      OP_SRL:  res_c = bus.alu_b >> shamt;
      OP_SRA:  res_c = $signed(bus.alu_b) >>> shamt;
      OP_SLL:  res_c = bus.alu_b << shamt;
      OP_LUI:  res_c = WIDTH'(bus.alu_b[15:0]) << 16;
      OP_MFHI: res_c = hi_q;
      OP_MFLO: res_c = lo_q;
      OP_MTHI: res_c = bus.alu_a;
      OP_MTLO: res_c = bus.alu_a;
      default: res_c = '0;
    endcase
  end

  // One iteration step of each engine, plus the sign-fixed final result.
  // A zero divisor bypasses sign fixing so hi keeps the raw dividend.
  always_comb begin
    upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    shifted   = {rem, quo[WIDTH-1]};
    fits      = shifted >= {1'b0, divisor};
    div_diff  = shifted[WIDTH-1:0] - divisor;
    if (is_div) begin
      if (div_zero) begin
        fix_lo = '1;
        fix_hi = dividend_raw;
      end else begin
        fix_lo = neg_q ? -quo : quo;
        fix_hi = neg_r ? -rem : rem;
      end
    end else begin
      {fix_hi, fix_lo} = neg_q ? -prod : prod;
    end
  end

  // Control and datapath registers. Flush returns to IDLE without writing
  // hi/lo, and takes priority over any accept in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      count        <= '0;
      prod         <= '0;
      mcand        <= '0;
      divisor      <= '0;
      quo          <= '0;
      rem          <= '0;
      dividend_raw <= '0;
      is_div       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      out_valid_q  <= 1'b0;
      ov_q         <= 1'b0;
      res_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept && is_multi) begin
              is_div       <= (bus.alu_op == OP_DIV) || (bus.alu_op == OP_DIVU);
              state        <= ((bus.alu_op == OP_DIV) || (bus.alu_op == OP_DIVU)) ? S_DIV : S_MUL;
              count        <= '0;
              prod         <= {{WIDTH{1'b0}}, b_mag};
              mcand        <= a_mag;
              quo          <= a_mag;
              rem          <= '0;
              divisor      <= b_mag;
              dividend_raw <= bus.alu_a;
              neg_q        <= a_neg ^ b_neg;
              neg_r        <= a_neg;
              div_zero     <= (bus.alu_b == '0);
            end else if (accept) begin
              out_valid_q <= 1'b1;
              res_q       <= res_c;
              ov_q        <= ov_c;
              if (bus.alu_op == OP_MTHI) hi_q <= bus.alu_a;
              if (bus.alu_op == OP_MTLO) lo_q <= bus.alu_a;
            end
          end
          S_MUL: begin
            prod  <= {upper_sum, prod[WIDTH-1:1]};
            count <= count + 1'b1;
            if (count == SHW'(WIDTH-1)) state <= S_FIX;
          end
          S_DIV: begin
            rem   <= fits ? div_diff : shifted[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], fits};
            count <= count + 1'b1;
            if (count == SHW'(WIDTH-1)) state <= S_FIX;
          end
          default: begin
            hi_q        <= fix_hi;
            lo_q        <= fix_lo;
            res_q       <= fix_lo;
            ov_q        <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= S_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: self-checking bench for alu_md at WIDTH=32 (full feature set)
// and WIDTH=64 (multiply/divide latency and results). Expected values come
// from directed constants and an arithmetic reference model.
module tb_alu_md;
  localparam logic [4:0] OP_AND = 5'b00000, OP_ADD = 5'b00001, OP_MULT = 5'b00010,
                         OP_MULTU = 5'b00011, OP_SRL = 5'b00100, OP_DIV = 5'b00110,
                         OP_DIVU = 5'b00111, OP_OR = 5'b01000, OP_SUB = 5'b01001,
                         OP_SLT = 5'b01010, OP_SLTU = 5'b01011, OP_SRA = 5'b01100,
                         OP_MFHI = 5'b01101, OP_MFLO = 5'b01110, OP_MTHI = 5'b01111,
                         OP_NOR = 5'b10000, OP_MTLO = 5'b10001, OP_SLL = 5'b10100,
                         OP_XOR = 5'b11000, OP_LUI = 5'b11100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  alu_md_if #(.WIDTH(32)) bus32 ();
  alu_md_if #(.WIDTH(64)) bus64 ();

  alu_md #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(bus32));
  alu_md #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .flush(flush), .bus(bus64));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        src;
    logic [31:0] r;
    logic        ov;
  } vec_t;

  // Reference for single-cycle ops, from plain integer arithmetic.
  function automatic void model_single(input logic [4:0] op, input logic [31:0] a, b,
                                       input logic src, output logic [31:0] r, output logic ov);
    int     sh;
    longint s;
    sh = src ? int'(a[10:6]) : int'(a[4:0]);
    r  = '0;
    ov = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_XOR: r = a ^ b;
      OP_ADD: begin
        s  = longint'($signed(a)) + longint'($signed(b));
        r  = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        s  = longint'($signed(a)) - longint'($signed(b));
        r  = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_SRL:  r = b >> sh;
      OP_SRA:  r = $signed(b) >>> sh;
      OP_SLL:  r = b << sh;
      OP_LUI:  r = {b[15:0], 16'h0000};
      OP_MFHI: r = model_hi;
      OP_MFLO: r = model_lo;
      OP_MTHI: r = a;
      OP_MTLO: r = a;
      default: r = '0;
    endcase
  endfunction

  // Reference for multiply/divide: {hi,lo} from wide arithmetic.
  function automatic void model_multi(input logic [4:0] op, input logic [31:0] a, b,
                                      output logic [31:0] h, output logic [31:0] l);
    longint p;
    logic [63:0] pu;
    int q, m;
    h = '0;
    l = '0;
    if (op == OP_MULT) begin
      p = longint'($signed(a)) * longint'($signed(b));
      h = p[63:32];
      l = p[31:0];
    end else if (op == OP_MULTU) begin
      pu = {32'h0, a} * {32'h0, b};
      h = pu[63:32];
      l = pu[31:0];
    end else if (b == 32'h0) begin
      l = 32'hFFFFFFFF;
      h = a;
    end else if (op == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      l = a;
      h = '0;
    end else if (op == OP_DIV) begin
      q = $signed(a) / $signed(b);
      m = $signed(a) % $signed(b);
      l = q;
      h = m;
    end else begin
      l = a / b;
      h = a % b;
    end
  endfunction

  task automatic drive32(input logic [4:0] op, input logic [31:0] a, b, input logic src);
    bus32.in_valid = 1'b1;
    bus32.alu_op   = op;
    bus32.alu_a    = a;
    bus32.alu_b    = b;
    bus32.alu_srcA = src;
    @(posedge clk);
    #1;
  endtask

  // Issue one multi-cycle op and watch it to completion, scrambling the
  // inputs while busy. lat is -1 if no strobe arrived within the bound.
  task automatic run_multi32(input logic [4:0] op, input logic [31:0] a, b, output int lat,
                             output bit ready_bad, output logic [31:0] rh, rl, rr);
    lat = -1; ready_bad = 1'b0; rh = '0; rl = '0; rr = '0;
    drive32(op, a, b, 1'b0);
    bus32.in_valid = 1'b0;
    if (bus32.out_valid || bus32.in_ready) ready_bad = 1'b1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      bus32.alu_a  = $urandom;
      bus32.alu_b  = $urandom;
      bus32.alu_op = 5'($urandom);
      @(posedge clk);
      #1;
      if (bus32.out_valid) begin
        lat = i; rh = bus32.hi; rl = bus32.lo; rr = bus32.alu_res;
        if (!bus32.in_ready) ready_bad = 1'b1;
      end else if (bus32.in_ready) begin
        ready_bad = 1'b1;
      end
    end
  endtask

  task automatic run_multi64(input logic [4:0] op, input logic [63:0] a, b, output int lat,
                             output logic [63:0] rh, rl);
    lat = -1; rh = '0; rl = '0;
    bus64.in_valid = 1'b1;
    bus64.alu_op   = op;
    bus64.alu_a    = a;
    bus64.alu_b    = b;
    bus64.alu_srcA = 1'b0;
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    for (int i = 1; i <= 80 && lat < 0; i++) begin
      bus64.alu_a = {$urandom, $urandom};
      @(posedge clk);
      #1;
      if (bus64.out_valid) begin
        lat = i; rh = bus64.hi; rl = bus64.lo;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    n_cmp++;
    if ({bus32.in_ready, bus32.out_valid, bus32.alu_int_ov} !== 3'b100) begin
      n_err++; $display("[TB] FAIL reset_flags: got %b want 100", {bus32.in_ready, bus32.out_valid, bus32.alu_int_ov});
    end
    n_cmp++;
    if ({bus32.alu_res, bus32.hi, bus32.lo} !== 96'h0) begin
      n_err++; $display("[TB] FAIL reset_regs: got res=%h hi=%h lo=%h want 0", bus32.alu_res, bus32.hi, bus32.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_directed();
    vec_t tbl[10];
    tbl[0] = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b1};
    tbl[1] = '{OP_SUB,  32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1};
    tbl[2] = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000001, 1'b0};
    tbl[3] = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0};
    tbl[4] = '{OP_SRA,  32'h00000100, 32'hF0000000, 1'b1, 32'hFF000000, 1'b0};
    tbl[5] = '{OP_SRL,  32'h00000100, 32'hF0000000, 1'b1, 32'h0F000000, 1'b0};
    tbl[6] = '{OP_LUI,  32'h00000000, 32'h00001234, 1'b0, 32'h12340000, 1'b0};
    tbl[7] = '{OP_SLL,  32'h00000104, 32'h0000000F, 1'b0, 32'h000000F0, 1'b0};
    tbl[8] = '{OP_ADD,  32'h00000005, 32'hFFFFFFFE, 1'b0, 32'h00000003, 1'b0};
    tbl[9] = '{5'b11111, 32'h000000FF, 32'h000000FF, 1'b0, 32'h00000000, 1'b0};
    // Issued back-to-back with in_valid held high.
    for (int i = 0; i < 10; i++) begin
      drive32(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].src);
      n_cmp++;
      if ({bus32.out_valid, bus32.alu_int_ov, bus32.alu_res} !== {1'b1, tbl[i].ov, tbl[i].r}) begin
        n_err++; $display("[TB] FAIL single_%0d: got v=%b ov=%b res=%h want v=1 ov=%b res=%h",
                          i, bus32.out_valid, bus32.alu_int_ov, bus32.alu_res, tbl[i].ov, tbl[i].r);
      end
    end
    bus32.in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus32.out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL strobe_one_cycle: got out_valid=%b want 0", bus32.out_valid);
    end
  endtask

  task automatic test_mthi_mfhi();
    drive32(OP_MTHI, 32'h000000A5, 32'h0, 1'b0);
    model_hi = 32'h000000A5;
    drive32(OP_MFHI, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if ({bus32.out_valid, bus32.alu_res} !== {1'b1, 32'h000000A5}) begin
      n_err++; $display("[TB] FAIL mfhi_b2b: got v=%b res=%h want v=1 res=000000a5", bus32.out_valid, bus32.alu_res);
    end
    drive32(OP_MTLO, 32'h5A5A0001, 32'h0, 1'b0);
    model_lo = 32'h5A5A0001;
    drive32(OP_MFLO, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if (bus32.alu_res !== 32'h5A5A0001 || bus32.lo !== 32'h5A5A0001) begin
      n_err++; $display("[TB] FAIL mflo_b2b: got res=%h lo=%h want 5a5a0001", bus32.alu_res, bus32.lo);
    end
    bus32.in_valid = 1'b0;
  endtask

  task automatic test_multi_directed();
    vec_t tbl[5];
    logic [31:0] exp_hi[5];
    int lat;
    bit rb;
    logic [31:0] rh, rl, rr;
    tbl[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 1'b0, 32'hFFFFFFEB, 1'b0}; exp_hi[0] = 32'hFFFFFFFF;
    tbl[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b0}; exp_hi[1] = 32'hFFFFFFFE;
    tbl[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFD, 1'b0}; exp_hi[2] = 32'hFFFFFFFF;
    tbl[3] = '{OP_DIVU,  32'h00000007, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0}; exp_hi[3] = 32'h00000007;
    tbl[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b0}; exp_hi[4] = 32'h00000000;
    for (int i = 0; i < 5; i++) begin
      run_multi32(tbl[i].op, tbl[i].a, tbl[i].b, lat, rb, rh, rl, rr);
      n_cmp++;
      if (lat != 33 || rb) begin
        n_err++; $display("[TB] FAIL multi_timing_%0d: got latency=%0d ready_violation=%0d want 33/0", i, lat, rb);
      end
      n_cmp++;
      if ({rh, rl, rr} !== {exp_hi[i], tbl[i].r, tbl[i].r}) begin
        n_err++; $display("[TB] FAIL multi_result_%0d: got hi=%h lo=%h res=%h want hi=%h lo=%h",
                          i, rh, rl, rr, exp_hi[i], tbl[i].r);
      end
      model_hi = exp_hi[i];
      model_lo = tbl[i].r;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus32.out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL multi_strobe_once: got out_valid=%b want 0", bus32.out_valid);
    end
  endtask

  task automatic test_width64();
    int lat;
    logic [63:0] rh, rl, a, b;
    logic [127:0] p;
    run_multi64(OP_MULTU, '1, '1, lat, rh, rl);
    n_cmp++;
    if (lat != 65 || rh !== 64'hFFFFFFFFFFFFFFFE || rl !== 64'h1) begin
      n_err++; $display("[TB] FAIL w64_multu_max: got lat=%0d hi=%h lo=%h want 65 fffffffffffffffe 1", lat, rh, rl);
    end
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 3 == 0) begin
        p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        run_multi64(OP_MULT, a, b, lat, rh, rl);
      end else if (i % 3 == 1) begin
        p = {64'h0, a} * {64'h0, b};
        run_multi64(OP_MULTU, a, b, lat, rh, rl);
      end else begin
        b = b >> 40;
        if (b == 64'h0) b = 64'd3;
        p = {a % b, a / b};
        run_multi64(OP_DIVU, a, b, lat, rh, rl);
      end
      n_cmp++;
      if (lat != 65 || {rh, rl} !== p) begin
        n_err++; $display("[TB] FAIL w64_rand_%0d: got lat=%0d hi=%h lo=%h want 65 %h", i, lat, rh, rl, p);
      end
    end
  endtask

  task automatic test_flush();
    bit seen;
    // Flush during iteration 10 of a DIV.
    drive32(OP_DIV, 32'h12345678, 32'h00000013, 1'b0);
    bus32.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    n_cmp++;
    if ({bus32.out_valid, bus32.in_ready, bus32.hi, bus32.lo} !== {2'b01, model_hi, model_lo}) begin
      n_err++; $display("[TB] FAIL flush_div: got v=%b rdy=%b hi=%h lo=%h want 0 1 %h %h",
                        bus32.out_valid, bus32.in_ready, bus32.hi, bus32.lo, model_hi, model_lo);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus32.out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++; $display("[TB] FAIL flush_no_late_strobe: got a strobe after flush want none");
    end
    // Flush in the sign-fix cycle of a MULT.
    drive32(OP_MULT, 32'h00001000, 32'h00000300, 1'b0);
    bus32.in_valid = 1'b0;
    repeat (32) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    n_cmp++;
    if ({bus32.out_valid, bus32.in_ready, bus32.hi, bus32.lo} !== {2'b01, model_hi, model_lo}) begin
      n_err++; $display("[TB] FAIL flush_fix: got v=%b rdy=%b hi=%h lo=%h want 0 1 %h %h",
                        bus32.out_valid, bus32.in_ready, bus32.hi, bus32.lo, model_hi, model_lo);
    end
    // MTHI accepted together with flush must not write.
    flush = 1'b1;
    drive32(OP_MTHI, 32'hDEADBEEF, 32'h0, 1'b0);
    flush = 1'b0;
    bus32.in_valid = 1'b0;
    n_cmp++;
    if ({bus32.out_valid, bus32.hi} !== {1'b0, model_hi}) begin
      n_err++; $display("[TB] FAIL flush_mthi: got v=%b hi=%h want 0 %h", bus32.out_valid, bus32.hi, model_hi);
    end
  endtask

  task automatic test_random();
    logic [4:0] ops[24];
    logic [4:0] op;
    logic [31:0] a, b, er, eh, el, rh, rl, rr;
    logic eov, src;
    int lat;
    bit rb;
    ops = '{OP_AND, OP_ADD, OP_OR, OP_NOR, OP_XOR, OP_SUB, OP_SLT, OP_SLTU, OP_SRL, OP_SRA,
            OP_SLL, OP_LUI, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, 5'b00101, 5'b11111,
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_MULT};
    for (int i = 0; i < 60; i++) begin
      op  = ops[$urandom_range(0, 23)];
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      src = 1'($urandom_range(0, 1));
      if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU) begin
        model_multi(op, a, b, eh, el);
        run_multi32(op, a, b, lat, rb, rh, rl, rr);
        n_cmp++;
        if (lat != 33 || rb || {rh, rl, rr} !== {eh, el, el}) begin
          n_err++; $display("[TB] FAIL rand_multi_%0d op=%b a=%h b=%h: got lat=%0d rb=%0d hi=%h lo=%h res=%h want 33 0 %h %h",
                            i, op, a, b, lat, rb, rh, rl, rr, eh, el);
        end
        model_hi = eh;
        model_lo = el;
      end else begin
        model_single(op, a, b, src, er, eov);
        drive32(op, a, b, src);
        n_cmp++;
        if ({bus32.out_valid, bus32.alu_int_ov, bus32.alu_res} !== {1'b1, eov, er}) begin
          n_err++; $display("[TB] FAIL rand_single_%0d op=%b a=%h b=%h: got v=%b ov=%b res=%h want 1 %b %h",
                            i, op, a, b, bus32.out_valid, bus32.alu_int_ov, bus32.alu_res, eov, er);
        end
        if (op == OP_MTHI) model_hi = a;
        if (op == OP_MTLO) model_lo = a;
      end
    end
    bus32.in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus32.hi, bus32.lo} !== {model_hi, model_lo}) begin
      n_err++; $display("[TB] FAIL rand_hilo: got hi=%h lo=%h want %h %h", bus32.hi, bus32.lo, model_hi, model_lo);
    end
  endtask

  task automatic test_reset_mid_mult();
    drive32(OP_MTHI, 32'h00001234, 32'h0, 1'b0);
    drive32(OP_MULT, 32'h00000123, 32'h00000456, 1'b0);
    bus32.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus32.in_ready, bus32.out_valid, bus32.alu_int_ov, bus32.alu_res, bus32.hi, bus32.lo} !== {3'b100, 96'h0}) begin
      n_err++; $display("[TB] FAIL reset_mid_mult: got rdy=%b v=%b ov=%b res=%h hi=%h lo=%h want 1 0 0 0 0 0",
                        bus32.in_ready, bus32.out_valid, bus32.alu_int_ov, bus32.alu_res, bus32.hi, bus32.lo);
    end
    n_cmp++;
    if ({bus64.in_ready, bus64.hi, bus64.lo} !== {1'b1, 128'h0}) begin
      n_err++; $display("[TB] FAIL reset_w64: got rdy=%b hi=%h lo=%h want 1 0 0", bus64.in_ready, bus64.hi, bus64.lo);
    end
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus32.in_valid = 1'b0; bus32.alu_op = '0; bus32.alu_srcA = 1'b0; bus32.alu_a = '0; bus32.alu_b = '0;
    bus64.in_valid = 1'b0; bus64.alu_op = '0; bus64.alu_srcA = 1'b0; bus64.alu_a = '0; bus64.alu_b = '0;
    test_reset();
    test_single_directed();
    test_mthi_mfhi();
    test_multi_directed();
    test_width64();
    test_flush();
    test_random();
    test_reset_mid_mult();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised, registered successor to the single-cycle ALU.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, plus a valid/ready issue handshake and a flush input.
- Sits in the EX stage.
- Single-cycle ops return in 1 cycle; MULT/DIV ops hold the stage busy until they complete.

Parameters:
- WIDTH, 32, datapath width; power of 2, minimum 16.
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  cancel in-flight op (exception/branch kill).
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an op this cycle.
- alu_op  in  5  operation code.
- alu_srcA  in  1  shift amount from alu_a[6+:SHW] (1) or alu_a[SHW-1:0] (0).
- alu_a  in  WIDTH  operand A.
- alu_b  in  WIDTH  operand B.
- out_valid  out  1  single-cycle result strobe.
- alu_res  out  WIDTH  result.
- alu_int_ov  out  1  signed overflow (ADD/SUB only).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Op codes (existing):
  - 00000 AND; 00001 ADD; 01000 OR; 10000 NOR; 11000 XOR; 01001 SUB.
  - 01010 SLT (signed); 01011 SLTU.
  - 00100 SRL; 01100 SRA; 10100 SLL; 11100 LUI (alu_b[15:0]<<16, zero-filled).
- Op codes (new): 00010 MULT; 00011 MULTU; 00110 DIV; 00111 DIVU; 01101 MFHI; 01110 MFLO; 01111 MTHI; 10001 MTLO.
- Undefined codes: alu_res=0, strobe still issued.
- Reset (reset=0, async): state IDLE; in_ready=1; out_valid=0; alu_res=0; alu_int_ov=0; hi=0; lo=0.
- Accept: an op is accepted on a clk edge with in_valid & in_ready. in_ready=1 only in IDLE.
- Single-cycle ops (all except MULT/MULTU/DIV/DIVU):
  - Accepted at edge T; alu_res, alu_int_ov and out_valid=1 are registered at T and held for exactly one cycle.
  - Back-to-back issue at full rate is allowed.
  - MTHI/MTLO write hi/lo at edge T; alu_res=alu_a.
  - MFHI/MFLO return the hi/lo value current before edge T.
- Overflow:
  - ADD: ov = (a[W-1]==b[W-1]) & (r[W-1]!=a[W-1]).
  - SUB: ov = (a[W-1]!=b[W-1]) & (r[W-1]!=a[W-1]).
  - All other ops: ov=0.
  - alu_res is still the wrapped result.
- Shifts: operate on alu_b. SRA is arithmetic; shift amount is selected by alu_srcA.
- State machine: IDLE -> MUL or DIV on accept -> (WIDTH iteration cycles) -> FIX -> IDLE.
  - MUL: shift-add, one bit per cycle, on operand magnitudes.
  - DIV: restoring, one quotient bit per cycle, on magnitudes.
  - FIX: sign correction.
    - Signed product negated if operand signs differ.
    - Quotient negated if signs differ; remainder takes the dividend's sign (truncation toward zero).
- Multi-cycle timing:
  - Accepted at edge T; iterations occupy edges T+1..T+WIDTH; FIX at edge T+WIDTH+1.
  - At edge T+WIDTH+1: {hi,lo} are written, out_valid=1 for one cycle, alu_res=lo.
  - in_ready=0 from after edge T until the cycle after completion.
  - MULT/MULTU: {hi,lo} = 2*WIDTH-bit product.
  - DIV/DIVU: lo=quotient, hi=remainder.
- Divide corner cases:
  - Divisor 0: lo=all ones, hi=dividend. No trap; completes with normal latency.
  - Signed MIN / -1: lo=MIN, hi=0.
- Flush:
  - Kills any op accepted in the same cycle or in flight.
  - Next state IDLE; out_valid=0; hi/lo unchanged, including a flush in the FIX cycle.
  - flush has priority over accept.
  - A single-cycle MTHI/MTLO accepted with flush=1 does not write.
- Operands are latched at accept; input changes during busy have no effect.
- Reset asserted mid-operation aborts immediately to reset values.

Test Plan:
- Single-cycle sweep (WIDTH=32): ADD 0x7FFFFFFF+1 -> alu_res=0x80000000, ov=1, out_valid one cycle after accept. SUB 0x80000000-1 -> 0x7FFFFFFF, ov=1. SLT -1<1 -> 1. SLTU 0xFFFFFFFF<1 -> 0.
- Shifts: SRA alu_b=0xF0000000 with alu_srcA=1, alu_a[10:6]=4 -> 0xFF000000. SRL, same operands, -> 0x0F000000. LUI alu_b=0x1234 -> 0x12340000.
- MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, out_valid exactly 33 cycles after accept, in_ready low throughout. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- MTHI 0xA5 then MFHI back-to-back -> second result=0xA5. Flush at iteration 10 of a DIV -> no out_valid, hi/lo unchanged, in_ready=1 next cycle.
- Reset low mid-MULT -> all outputs 0 asynchronously. Rerun at WIDTH=64: MULTU max*max -> hi=0xFFFFFFFFFFFFFFFE, lo=1, latency 65.
